// File: rtl/card_bus_arbiter.sv
// Shares the Apple II bridge data-out path among slot cards: one grant per phi0, hold-off, then drive.
// Define CARD_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (index 0 first) otherwise.
module card_bus_arbiter #(
    parameter int NUM_CARDS          = 3,
    parameter int HOLDOFF_CYCLES     = 2,
    parameter int CONFLICT_CNT_WIDTH = 8
) (
    input  logic                          clk_logic,
    input  logic                          device_reset_n,
    input  logic                          phi1_posedge_i,
    input  logic                          phi1_negedge_i,
    input  logic [NUM_CARDS-1:0]          rd_en_i,
    input  logic [NUM_CARDS*8-1:0]        data_i,
    input  logic [7:0]                    passthru_data_i,
    input  logic [NUM_CARDS-1:0]          irq_n_i,
    input  logic [NUM_CARDS-1:0]          irq_mask_i,
    output logic                          data_out_en_o,
    output logic [7:0]                    data_out_o,
    output logic [NUM_CARDS-1:0]          grant_o,
    output logic                          irq_n_o,
    output logic                          conflict_o,
    output logic [CONFLICT_CNT_WIDTH-1:0] conflict_count_o,
    output logic                          busy_o
);

    localparam int unsigned NC    = NUM_CARDS;
    localparam int          CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        HOLDOFF,
        DRIVE
    } state_t;

    state_t               state_q, state_nx;
    logic [CNT_W-1:0]     hold_q, hold_nx;
    logic [NUM_CARDS-1:0] arb_gnt, grant_nx;
    logic                 arbitrate, conflict_nx;
    logic [7:0]           drive_byte;

    assign arbitrate   = phi1_negedge_i && !phi1_posedge_i;
    assign conflict_nx = arbitrate && ($countones(rd_en_i) > 1);

`ifdef CARD_ARB_ROUND_ROBIN_EN
    localparam int PTR_W = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_nx;

    // Winner is the requester at the smallest circular distance past the last grant.
    always_comb begin : rr_pick
        int unsigned best;
        int unsigned dist;
        arb_gnt = '0;
        ptr_nx  = ptr_q;
        best    = NC;
        dist    = 0;
        for (int unsigned k = 0; k < NC; k++) begin
            dist = (k + NC - 32'(ptr_q) - 1) % NC;
            if (rd_en_i[k] && dist < best) begin
                best    = dist;
                arb_gnt = NUM_CARDS'(1) << k;
                ptr_nx  = PTR_W'(k);
            end
        end
    end

    always_ff @(posedge clk_logic) begin
        if (!device_reset_n) begin
            ptr_q <= PTR_W'(NUM_CARDS - 1);
        end else if (arbitrate) begin
            ptr_q <= ptr_nx;
        end
    end
`else
    always_comb begin
        arb_gnt = '0;
        for (int unsigned k = 0; k < NC; k++) begin
            if (rd_en_i[k] && arb_gnt == '0) begin
                arb_gnt = NUM_CARDS'(1) << k;
            end
        end
    end
`endif

    // Priority: phi0 end, then a new phi0 start (re-arbitrate), then early release, then hold-off count.
    always_comb begin
        state_nx = state_q;
        hold_nx  = hold_q;
        grant_nx = grant_o;
        if (phi1_posedge_i) begin
            state_nx = IDLE;
            hold_nx  = '0;
            grant_nx = '0;
        end else if (phi1_negedge_i) begin
            if (rd_en_i == '0) begin
                state_nx = IDLE;
                hold_nx  = '0;
                grant_nx = '0;
            end else begin
                grant_nx = arb_gnt;
                if (HOLDOFF_CYCLES == 0) begin
                    state_nx = DRIVE;
                    hold_nx  = '0;
                end else begin
                    state_nx = HOLDOFF;
                    hold_nx  = HOLD_LOAD;
                end
            end
        end else if (state_q != IDLE && (rd_en_i & grant_o) == '0) begin
            state_nx = IDLE;
            hold_nx  = '0;
            grant_nx = '0;
        end else if (state_q == HOLDOFF) begin
            if (hold_q == '0) begin
                state_nx = DRIVE;
            end else begin
                hold_nx = hold_q - 1'b1;
            end
        end
    end

    always_comb begin
        drive_byte = '0;
        for (int unsigned k = 0; k < NC; k++) begin
            if (grant_nx[k]) begin
                drive_byte = drive_byte | data_i[8*k +: 8];
            end
        end
    end

    // Outputs are registered from the next-state values so they line up with the state register.
    always_ff @(posedge clk_logic) begin
        if (!device_reset_n) begin
            state_q          <= IDLE;
            hold_q           <= '0;
            grant_o          <= '0;
            busy_o           <= 1'b0;
            data_out_en_o    <= 1'b0;
            data_out_o       <= '0;
            conflict_o       <= 1'b0;
            conflict_count_o <= '0;
            irq_n_o          <= 1'b1;
        end else begin
            state_q       <= state_nx;
            hold_q        <= hold_nx;
            grant_o       <= grant_nx;
            busy_o        <= (state_nx != IDLE);
            data_out_en_o <= (state_nx == DRIVE);
            data_out_o    <= (state_nx == DRIVE) ? drive_byte : passthru_data_i;
            conflict_o    <= conflict_nx;
            if (conflict_nx && conflict_count_o != '1) begin
                conflict_count_o <= conflict_count_o + 1'b1;
            end
            irq_n_o <= &(irq_n_i | irq_mask_i);
        end
    end

endmodule
